// File: rtl/x2_detect_window_reporter_if.sv
// Report channel from the window reporter to its status/host consumer.
// The reporter drives valid and payload; the consumer drives ready.
interface x2_detect_window_reporter_if #(
    parameter int CNT_W = 8
) ();
    logic             rpt_valid;
    logic             rpt_ready;
    logic [CNT_W-1:0] rpt_count;
    logic             rpt_sat;
    logic             rpt_lost;

    modport master (output rpt_valid, rpt_count, rpt_sat, rpt_lost, input rpt_ready);
    modport slave  (input rpt_valid, rpt_count, rpt_sat, rpt_lost, output rpt_ready);
endinterface

// File: rtl/x2_detect_window_reporter.sv
// Counts rising edges of z over windows of WIN_LEN enabled cycles and offers one
// saturating count report per window over a valid/ready channel.
module x2_detect_window_reporter #(
    parameter int CNT_W   = 8,
    parameter int WIN_LEN = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic z,
    input  logic enable,
    x2_detect_window_reporter_if.master rpt
);
    localparam int               WIN_W    = (WIN_LEN > 2) ? $clog2(WIN_LEN) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0] ACC_MAX  = '1;

    typedef enum logic {IDLE, PEND} state_t;

    state_t             state_q, state_d;
    logic               z_q;
    logic [WIN_W-1:0]   win_cnt;
    logic [CNT_W-1:0]   acc;
    logic               acc_sat;
    logic               lost_pend;
    logic [CNT_W-1:0]   count_q;
    logic               sat_q;
    logic               lost_q;

    logic               evt;
    logic               win_end;
    logic               acc_full;
    logic               overflow;
    logic [CNT_W-1:0]   acc_next;
    logic               capture;
    logic               drop;

    assign evt      = z & ~z_q & enable;
    assign win_end  = enable & (win_cnt == WIN_LAST);
    assign acc_full = (acc == ACC_MAX);
    assign overflow = evt & acc_full;
    // acc_next already folds in this cycle's event, so a capture sees it too
    assign acc_next = (evt & ~acc_full) ? acc + CNT_W'(1) : acc;

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        drop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_end) begin
                    capture = 1'b1;
                    state_d = PEND;
                end
            end
            PEND: begin
                if (win_end) begin
                    // an accepted old report frees the slot for the new one
                    capture = rpt.rpt_ready;
                    drop    = ~rpt.rpt_ready;
                end else if (rpt.rpt_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            z_q     <= 1'b0;
            win_cnt <= '0;
            acc     <= '0;
            acc_sat <= 1'b0;
        end else begin
            z_q <= z;
            if (enable) win_cnt <= win_end ? '0 : win_cnt + WIN_W'(1);
            if (win_end) begin
                acc     <= '0;
                acc_sat <= 1'b0;
            end else begin
                acc     <= acc_next;
                acc_sat <= acc_sat | overflow;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lost_pend <= 1'b0;
            count_q   <= '0;
            sat_q     <= 1'b0;
            lost_q    <= 1'b0;
        end else begin
            if (capture) begin
                count_q   <= acc_next;
                sat_q     <= acc_sat | overflow;
                lost_q    <= lost_pend;
                lost_pend <= 1'b0;
            end else if (drop) begin
                lost_pend <= 1'b1;
            end
        end
    end

    assign rpt.rpt_valid = (state_q == PEND);
    assign rpt.rpt_count = count_q;
    assign rpt.rpt_sat   = sat_q;
    assign rpt.rpt_lost  = lost_q;
endmodule
